// File: rtl/atm_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : atm_session_ctrl
//  Description : Multi-account ATM session controller. Card insertion, PIN
//                check with retry lockout, inactivity timeout, and balance /
//                withdraw / deposit / transfer against an on-chip table.
//  Revision    : 1.0 - initial multi-account release
// ============================================================================
module atm_session_ctrl #(
    parameter int NUM_ACCOUNTS = 4,
    parameter int AMT_W        = 32,
    parameter int PIN_W        = 14,
    parameter int ACCT_W       = 16,
    parameter int PIN_BASE     = 8030,
    parameter int ACCT_BASE    = 16'hD900,
    parameter int INIT_BALANCE = 100000,
    parameter int MAX_TRIES    = 3,
    parameter int WD_LIMIT     = 50000,
    parameter int TIMEOUT      = 1024,
    localparam int IDX_W       = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1,
    localparam int TMR_W       = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              card_in,
    input  logic [IDX_W-1:0]  card_idx,
    input  logic              pin_valid,
    input  logic [PIN_W-1:0]  pin,
    input  logic              op_valid,
    input  logic [2:0]        opcode,
    input  logic [AMT_W-1:0]  amount,
    input  logic [ACCT_W-1:0] dest_acct,
    input  logic              receipt_req,
    output logic              session_active,
    output logic              pin_ok,
    output logic              op_done,
    output logic [2:0]        err_code,
    output logic [AMT_W-1:0]  balance_out,
    output logic              receipt_pulse,
    output logic              ejected,
    output logic              card_retained
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [2:0] c_op_bal    = 3'd1;
    localparam logic [2:0] c_op_wd     = 3'd2;
    localparam logic [2:0] c_op_dep    = 3'd3;
    localparam logic [2:0] c_op_xfr    = 3'd4;

    localparam logic [2:0] c_err_ok    = 3'd0;
    localparam logic [2:0] c_err_pin   = 3'd1;
    localparam logic [2:0] c_err_funds = 3'd2;
    localparam logic [2:0] c_err_limit = 3'd3;
    localparam logic [2:0] c_err_ovf   = 3'd4;
    localparam logic [2:0] c_err_acct  = 3'd5;
    localparam logic [2:0] c_err_badop = 3'd6;
    localparam logic [2:0] c_err_lock  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PIN    = 3'd1,
        S_HOME   = 3'd2,
        S_EXEC   = 3'd3,
        S_EJECT  = 3'd4,
        S_RETAIN = 3'd5
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_cur;
    logic [TRY_W-1:0]        r_tries;
    logic [TMR_W-1:0]        r_tmr;
    logic [AMT_W-1:0]        r_wd_tot;
    logic [NUM_ACCOUNTS-1:0] r_lock;
    logic [AMT_W-1:0]        r_bal [NUM_ACCOUNTS];
    logic [2:0]              r_op;
    logic [AMT_W-1:0]        r_amt;
    logic [ACCT_W-1:0]       r_dest;
    logic                    r_rcpt;
    logic                    r_op_done;
    logic                    r_receipt;
    logic                    r_ejected;
    logic                    r_retained;
    logic [2:0]              r_err;
    logic [AMT_W-1:0]        r_bal_out;

    logic [TMR_W-1:0]        w_tmr_inc;
    logic                    w_timeout;
    logic [TRY_W-1:0]        w_tries_inc;
    logic                    w_idx_bad;
    logic [PIN_W-1:0]        w_pin_exp;
    logic [AMT_W-1:0]        w_src_bal;
    logic [ACCT_W-1:0]       w_dest_off;
    logic [IDX_W-1:0]        w_dst;
    logic                    w_dest_ok;
    logic [AMT_W-1:0]        w_dst_bal;
    logic [AMT_W:0]          w_dep_sum;
    logic [AMT_W:0]          w_xfr_sum;
    logic [AMT_W:0]          w_wd_sum;
    logic [AMT_W-1:0]        w_debit;
    logic [2:0]              w_err;

    assign w_tmr_inc   = r_tmr + 1'b1;
    assign w_timeout   = (w_tmr_inc == TMR_W'(TIMEOUT));
    assign w_tries_inc = r_tries + 1'b1;
    assign w_idx_bad   = (32'(card_idx) >= NUM_ACCOUNTS);
    assign w_pin_exp   = PIN_W'(PIN_BASE + 32'(r_cur));
    assign w_src_bal   = r_bal[r_cur];
    // Offset wraps to a large value below the base, so one compare covers both ends
    assign w_dest_off  = r_dest - ACCT_W'(ACCT_BASE);
    assign w_dst       = w_dest_off[IDX_W-1:0];
    assign w_dest_ok   = (32'(w_dest_off) < NUM_ACCOUNTS) && (w_dst != r_cur);
    assign w_dst_bal   = r_bal[w_dst];
    assign w_dep_sum   = {1'b0, w_src_bal} + {1'b0, r_amt};
    assign w_xfr_sum   = {1'b0, w_dst_bal} + {1'b0, r_amt};
    assign w_wd_sum    = {1'b0, r_wd_tot} + {1'b0, r_amt};
    assign w_debit     = w_src_bal - r_amt;

    // Result code of the captured operation; the first failing check wins
    always_comb begin
        w_err = c_err_ok;
        case (r_op)
            c_op_bal: w_err = c_err_ok;
            c_op_wd: begin
                if (r_amt == '0)                          w_err = c_err_badop;
                else if (r_amt > w_src_bal)               w_err = c_err_funds;
                else if (w_wd_sum > (AMT_W+1)'(WD_LIMIT)) w_err = c_err_limit;
            end
            c_op_dep: begin
                if (r_amt == '0)          w_err = c_err_badop;
                else if (w_dep_sum[AMT_W]) w_err = c_err_ovf;
            end
            c_op_xfr: begin
                if (r_amt == '0)           w_err = c_err_badop;
                else if (!w_dest_ok)        w_err = c_err_acct;
                else if (r_amt > w_src_bal) w_err = c_err_funds;
                else if (w_xfr_sum[AMT_W])  w_err = c_err_ovf;
            end
            default: w_err = c_err_badop;
        endcase
    end

    // Session FSM, balance table and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cur      <= '0;
            r_tries    <= '0;
            r_tmr      <= '0;
            r_wd_tot   <= '0;
            r_lock     <= '0;
            r_op       <= '0;
            r_amt      <= '0;
            r_dest     <= '0;
            r_rcpt     <= 1'b0;
            r_op_done  <= 1'b0;
            r_receipt  <= 1'b0;
            r_ejected  <= 1'b0;
            r_retained <= 1'b0;
            r_err      <= c_err_ok;
            r_bal_out  <= '0;
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                r_bal[i] <= AMT_W'(INIT_BALANCE);
            end
        end else begin
            r_op_done  <= 1'b0;
            r_receipt  <= 1'b0;
            r_ejected  <= 1'b0;
            r_retained <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (card_in) begin
                        if (w_idx_bad) begin
                            r_err     <= c_err_acct;
                            r_ejected <= 1'b1;
                            r_state   <= S_EJECT;
                        end else if (r_lock[card_idx]) begin
                            r_err     <= c_err_lock;
                            r_ejected <= 1'b1;
                            r_state   <= S_EJECT;
                        end else begin
                            r_cur    <= card_idx;
                            r_tries  <= '0;
                            r_tmr    <= '0;
                            r_wd_tot <= '0;
                            r_state  <= S_PIN;
                        end
                    end
                end
                S_PIN: begin
                    if (pin_valid) begin
                        r_tmr     <= '0;
                        r_op_done <= 1'b1;
                        if (pin == w_pin_exp) begin
                            r_err     <= c_err_ok;
                            r_bal_out <= w_src_bal;
                            r_state   <= S_HOME;
                        end else begin
                            r_err   <= c_err_pin;
                            r_tries <= w_tries_inc;
                            if (w_tries_inc == TRY_W'(MAX_TRIES)) begin
                                r_lock[r_cur] <= 1'b1;
                                r_retained    <= 1'b1;
                                r_state       <= S_RETAIN;
                            end
                        end
                    end else if (w_timeout) begin
                        r_tmr     <= '0;
                        r_err     <= c_err_ok;
                        r_ejected <= 1'b1;
                        r_state   <= S_EJECT;
                    end else begin
                        r_tmr <= w_tmr_inc;
                    end
                end
                S_HOME: begin
                    if (op_valid) begin
                        r_tmr <= '0;
                        if (opcode == 3'd0) begin
                            r_err     <= c_err_ok;
                            r_ejected <= 1'b1;
                            r_state   <= S_EJECT;
                        end else begin
                            r_op    <= opcode;
                            r_amt   <= amount;
                            r_dest  <= dest_acct;
                            r_rcpt  <= receipt_req;
                            r_state <= S_EXEC;
                        end
                    end else if (w_timeout) begin
                        r_tmr     <= '0;
                        r_err     <= c_err_ok;
                        r_ejected <= 1'b1;
                        r_state   <= S_EJECT;
                    end else begin
                        r_tmr <= w_tmr_inc;
                    end
                end
                S_EXEC: begin
                    r_op_done <= 1'b1;
                    r_err     <= w_err;
                    r_receipt <= (w_err == c_err_ok) && r_rcpt;
                    r_tmr     <= '0;
                    r_state   <= S_HOME;
                    r_bal_out <= w_src_bal;
                    if (w_err == c_err_ok) begin
                        case (r_op)
                            c_op_wd: begin
                                r_bal[r_cur] <= w_debit;
                                r_wd_tot     <= w_wd_sum[AMT_W-1:0];
                                r_bal_out    <= w_debit;
                            end
                            c_op_dep: begin
                                r_bal[r_cur] <= w_dep_sum[AMT_W-1:0];
                                r_bal_out    <= w_dep_sum[AMT_W-1:0];
                            end
                            c_op_xfr: begin
                                r_bal[r_cur] <= w_debit;
                                r_bal[w_dst] <= w_xfr_sum[AMT_W-1:0];
                                r_bal_out    <= w_debit;
                            end
                            default: r_bal_out <= w_src_bal;
                        endcase
                    end
                end
                S_EJECT:  r_state <= S_IDLE;
                S_RETAIN: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign session_active = (r_state != S_IDLE);
    assign pin_ok         = (r_state == S_HOME) || (r_state == S_EXEC);
    assign op_done        = r_op_done;
    assign err_code       = r_err;
    assign balance_out    = r_bal_out;
    assign receipt_pulse  = r_receipt;
    assign ejected        = r_ejected;
    assign card_retained  = r_retained;

endmodule
`default_nettype wire

// File: tb/tb_atm_session_ctrl.sv
`default_nettype none
module tb_atm_session_ctrl;

    localparam int     NACC = 4;
    localparam int     TOUT = 64;
    localparam longint MAXV = 64'hFFFF_FFFF;
    localparam longint WDL  = 50000;

    logic        clk = 1'b0;
    logic        reset;
    logic        card_in;
    logic [1:0]  card_idx;
    logic        pin_valid;
    logic [13:0] pin;
    logic        op_valid;
    logic [2:0]  opcode;
    logic [31:0] amount;
    logic [15:0] dest_acct;
    logic        receipt_req;
    logic        session_active;
    logic        pin_ok;
    logic        op_done;
    logic [2:0]  err_code;
    logic [31:0] balance_out;
    logic        receipt_pulse;
    logic        ejected;
    logic        card_retained;

    atm_session_ctrl #(
        .NUM_ACCOUNTS(NACC), .AMT_W(32), .PIN_W(14), .ACCT_W(16),
        .PIN_BASE(8030), .ACCT_BASE(16'hD900), .INIT_BALANCE(100000),
        .MAX_TRIES(3), .WD_LIMIT(50000), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .reset(reset), .card_in(card_in), .card_idx(card_idx),
        .pin_valid(pin_valid), .pin(pin), .op_valid(op_valid), .opcode(opcode),
        .amount(amount), .dest_acct(dest_acct), .receipt_req(receipt_req),
        .session_active(session_active), .pin_ok(pin_ok), .op_done(op_done),
        .err_code(err_code), .balance_out(balance_out), .receipt_pulse(receipt_pulse),
        .ejected(ejected), .card_retained(card_retained)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Account-level reference model
    longint m_bal [NACC];
    bit     m_lock [NACC];
    int     m_cur;
    int     m_tries;
    longint m_wd;

    typedef struct packed {
        logic [1:0]  idx;
        logic [2:0]  opc;
        logic [31:0] amt;
        logic [15:0] dst;
        logic        rq;
        logic [2:0]  e;
        logic [31:0] b;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NACC; i++) begin
            m_bal[i]  = 100000;
            m_lock[i] = 1'b0;
        end
        m_cur = 0; m_tries = 0; m_wd = 0;
    endfunction

    function automatic int model_op(input int opc, input longint amt, input int dst);
        int di;
        di = dst - 'hD900;
        case (opc)
            1: return 0;
            2: begin
                if (amt == 0) return 6;
                if (amt > m_bal[m_cur]) return 2;
                if (m_wd + amt > WDL) return 3;
                m_bal[m_cur] -= amt;
                m_wd += amt;
                return 0;
            end
            3: begin
                if (amt == 0) return 6;
                if (m_bal[m_cur] + amt > MAXV) return 4;
                m_bal[m_cur] += amt;
                return 0;
            end
            4: begin
                if (amt == 0) return 6;
                if (di < 0 || di >= NACC || di == m_cur) return 5;
                if (amt > m_bal[m_cur]) return 2;
                if (m_bal[di] + amt > MAXV) return 4;
                m_bal[m_cur] -= amt;
                m_bal[di] += amt;
                return 0;
            end
            default: return 6;
        endcase
    endfunction

    task automatic do_reset;
        reset = 1'b1; card_in = 1'b0; pin_valid = 1'b0; op_valid = 1'b0;
        tick;
        tick;
        chk("reset_flags", {session_active, pin_ok, op_done, err_code, receipt_pulse, ejected, card_retained}, 0);
        chk("reset_balance_out", balance_out, 0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic insert(input string tag, input int idx);
        card_idx = 2'(idx); card_in = 1'b1;
        tick;
        card_in = 1'b0;
        if (m_lock[idx]) begin
            chk({tag, "/locked_eject"}, ejected, 1);
            chk({tag, "/locked_err"}, err_code, 7);
            chk({tag, "/locked_no_pin"}, pin_ok, 0);
            tick;
            chk({tag, "/locked_idle"}, session_active, 0);
        end else begin
            chk({tag, "/card_active"}, session_active, 1);
            chk({tag, "/card_no_pinok"}, pin_ok, 0);
            m_cur = idx; m_tries = 0; m_wd = 0;
        end
    endtask

    task automatic enter_pin(input string tag, input logic [13:0] p, output bit home, output bit gone);
        pin = p; pin_valid = 1'b1;
        tick;
        pin_valid = 1'b0;
        home = 1'b0; gone = 1'b0;
        chk({tag, "/pin_done"}, op_done, 1);
        if (int'(p) == 8030 + m_cur) begin
            chk({tag, "/pin_err_ok"}, err_code, 0);
            chk({tag, "/pin_ok"}, pin_ok, 1);
            home = 1'b1;
        end else begin
            m_tries++;
            chk({tag, "/pin_err_bad"}, err_code, 1);
            if (m_tries == 3) begin
                m_lock[m_cur] = 1'b1;
                chk({tag, "/retained"}, card_retained, 1);
                tick;
                chk({tag, "/retain_idle"}, session_active, 0);
                gone = 1'b1;
            end else begin
                chk({tag, "/pin_not_ok"}, pin_ok, 0);
                chk({tag, "/pin_still_active"}, session_active, 1);
                chk({tag, "/no_retain"}, card_retained, 0);
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] opc, input logic [31:0] amt,
                         input logic [15:0] dst, input bit rq, input int e_err, input longint e_bal);
        opcode = opc; amount = amt; dest_acct = dst; receipt_req = rq; op_valid = 1'b1;
        tick;
        op_valid = 1'b0;
        chk({tag, "/exec_no_done"}, op_done, 0);
        chk({tag, "/exec_pin_ok"}, pin_ok, 1);
        chk({tag, "/exec_no_eject"}, ejected, 0);
        tick;
        chk({tag, "/done"}, op_done, 1);
        chk({tag, "/err"}, err_code, 64'(e_err));
        chk({tag, "/balance"}, balance_out, e_bal);
        chk({tag, "/receipt"}, receipt_pulse, 64'(rq && (e_err == 0)));
    endtask

    task automatic eject_op(input string tag);
        opcode = 3'd0; op_valid = 1'b1;
        tick;
        op_valid = 1'b0;
        chk({tag, "/eject"}, ejected, 1);
        chk({tag, "/eject_err"}, err_code, 0);
        chk({tag, "/eject_no_done"}, op_done, 0);
        tick;
        chk({tag, "/eject_idle"}, session_active, 0);
    endtask

    task automatic rand_op(output bit gone);
        int          r;
        logic [2:0]  opc;
        logic [31:0] amt;
        logic [15:0] dst;
        bit          rq;
        int          e;
        r = $urandom_range(0, 19);
        if (r == 0)       opc = 3'd0;
        else if (r <= 3)  opc = 3'd1;
        else if (r <= 8)  opc = 3'd2;
        else if (r <= 12) opc = 3'd3;
        else if (r <= 17) opc = 3'd4;
        else              opc = 3'($urandom_range(5, 7));
        case ($urandom_range(0, 5))
            0: amt = 32'd0;
            1: amt = 32'($urandom_range(1, 1000));
            2: amt = 32'($urandom_range(1000, 60000));
            3: amt = 32'(m_bal[m_cur]);
            4: amt = $urandom();
            default: amt = 32'(WDL - m_wd);
        endcase
        case ($urandom_range(0, 5))
            0: dst = 16'hD9FF;
            1: dst = 16'($urandom());
            default: dst = 16'('hD900 + $urandom_range(0, 3));
        endcase
        rq = 1'($urandom_range(0, 1));
        gone = 1'b0;
        if (opc == 3'd0) begin
            eject_op("rnd_eject");
            gone = 1'b1;
        end else begin
            e = model_op(int'(opc), longint'(amt), int'(dst));
            do_op("rnd_op", opc, amt, dst, rq, e, m_bal[m_cur]);
        end
    endtask

    initial begin : main
        bit          home, gone, bad;
        int          cur_sess, idx, nops;
        logic [13:0] p;

        tbl[0]  = '{2'd0, 3'd4, 32'd40000,      16'hD903, 1'b0, 3'd0, 32'd60000};
        tbl[1]  = '{2'd0, 3'd2, 32'd30000,      16'h0000, 1'b1, 3'd0, 32'd30000};
        tbl[2]  = '{2'd0, 3'd2, 32'd30000,      16'h0000, 1'b1, 3'd3, 32'd30000};
        tbl[3]  = '{2'd0, 3'd4, 32'd10,         16'hD9FF, 1'b0, 3'd5, 32'd30000};
        tbl[4]  = '{2'd0, 3'd4, 32'd10,         16'hD900, 1'b0, 3'd5, 32'd30000};
        tbl[5]  = '{2'd0, 3'd4, 32'd0,          16'hD901, 1'b0, 3'd6, 32'd30000};
        tbl[6]  = '{2'd0, 3'd2, 32'd0,          16'h0000, 1'b0, 3'd6, 32'd30000};
        tbl[7]  = '{2'd0, 3'd7, 32'd5,          16'h0000, 1'b0, 3'd6, 32'd30000};
        tbl[8]  = '{2'd0, 3'd5, 32'd5,          16'h0000, 1'b1, 3'd6, 32'd30000};
        tbl[9]  = '{2'd0, 3'd3, 32'd0,          16'h0000, 1'b0, 3'd6, 32'd30000};
        tbl[10] = '{2'd0, 3'd3, 32'hFFFFFFFF,   16'h0000, 1'b0, 3'd4, 32'd30000};
        tbl[11] = '{2'd0, 3'd3, 32'd5,          16'h0000, 1'b1, 3'd0, 32'd30005};
        tbl[12] = '{2'd0, 3'd2, 32'd40000,      16'h0000, 1'b0, 3'd2, 32'd30005};
        tbl[13] = '{2'd0, 3'd2, 32'd20000,      16'h0000, 1'b1, 3'd0, 32'd10005};
        tbl[14] = '{2'd0, 3'd2, 32'd1,          16'h0000, 1'b0, 3'd3, 32'd10005};
        tbl[15] = '{2'd0, 3'd1, 32'd0,          16'h0000, 1'b1, 3'd0, 32'd10005};
        tbl[16] = '{2'd0, 3'd4, 32'd10005,      16'hD901, 1'b0, 3'd0, 32'd0};
        tbl[17] = '{2'd0, 3'd2, 32'd1,          16'h0000, 1'b0, 3'd2, 32'd0};
        tbl[18] = '{2'd3, 3'd1, 32'd0,          16'h0000, 1'b0, 3'd0, 32'd140000};
        tbl[19] = '{2'd3, 3'd3, 32'd4294827295, 16'h0000, 1'b0, 3'd0, 32'hFFFFFFFF};
        tbl[20] = '{2'd3, 3'd3, 32'd1,          16'h0000, 1'b0, 3'd4, 32'hFFFFFFFF};
        tbl[21] = '{2'd2, 3'd4, 32'd1,          16'hD903, 1'b0, 3'd4, 32'd100000};
        tbl[22] = '{2'd2, 3'd4, 32'd100000,     16'hD900, 1'b1, 3'd0, 32'd0};
        tbl[23] = '{2'd2, 3'd1, 32'd0,          16'h0000, 1'b0, 3'd0, 32'd0};

        card_idx = '0; pin = '0; opcode = '0; amount = '0; dest_acct = '0; receipt_req = 1'b0;
        do_reset();

        // Basic session with exact op latency, closed by the eject opcode
        insert("s2", 2);
        enter_pin("s2_pin", 14'd8032, home, gone);
        void'(model_op(1, 0, 0));
        do_op("s2_bal", 3'd1, 32'd0, 16'h0, 1'b0, 0, 100000);
        eject_op("s2_end");

        // Three wrong PINs swallow the card, re-insertion is refused
        insert("lk", 1);
        enter_pin("lk_pin1", 14'd1, home, gone);
        enter_pin("lk_pin2", 14'd2, home, gone);
        enter_pin("lk_pin3", 14'd3, home, gone);
        chk("lk_gone", gone, 1);
        insert("lk_again", 1);

        // Table-driven operation vectors across several sessions
        cur_sess = -1;
        for (int i = 0; i < 24; i++) begin
            if (int'(tbl[i].idx) != cur_sess) begin
                if (cur_sess >= 0) eject_op("tbl_end");
                cur_sess = int'(tbl[i].idx);
                insert("tbl_card", cur_sess);
                enter_pin("tbl_pin", 14'(8030 + cur_sess), home, gone);
            end
            void'(model_op(int'(tbl[i].opc), longint'(tbl[i].amt), int'(tbl[i].dst)));
            do_op($sformatf("tbl%0d", i), tbl[i].opc, tbl[i].amt, tbl[i].dst, tbl[i].rq,
                  int'(tbl[i].e), longint'(tbl[i].b));
        end
        eject_op("tbl_end");

        // Idle timeout in HOME
        do_reset();
        insert("to", 0);
        enter_pin("to_pin", 14'd8030, home, gone);
        bad = 1'b0;
        repeat (TOUT - 1) begin
            tick;
            if (ejected !== 1'b0 || pin_ok !== 1'b1) bad = 1'b1;
        end
        chk("to_not_early", bad, 0);
        tick;
        chk("to_eject", ejected, 1);
        chk("to_eject_err", err_code, 0);
        tick;
        chk("to_idle", session_active, 0);

        // Strobe on the final idle cycle wins over the timeout
        insert("to2", 0);
        enter_pin("to2_pin", 14'd8030, home, gone);
        repeat (TOUT - 1) tick;
        void'(model_op(1, 0, 0));
        do_op("to2_bal", 3'd1, 32'd0, 16'h0, 1'b0, 0, 100000);
        eject_op("to2_end");

        // Reset while an operation is executing
        insert("rx", 0);
        enter_pin("rx_pin", 14'd8030, home, gone);
        opcode = 3'd2; amount = 32'd1000; op_valid = 1'b1;
        tick;
        op_valid = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rx_idle", session_active, 0);
        chk("rx_no_done", op_done, 0);
        chk("rx_err_clear", err_code, 0);
        model_reset();
        insert("rx2", 0);
        enter_pin("rx2_pin", 14'd8030, home, gone);
        void'(model_op(2, 1000, 0));
        do_op("rx2_wd", 3'd2, 32'd1000, 16'h0, 1'b0, 0, 99000);
        // A card pulse mid-session must not switch accounts
        card_idx = 2'd3; card_in = 1'b1;
        tick;
        card_in = 1'b0;
        chk("rx2_card_ignored", pin_ok, 1);
        void'(model_op(1, 0, 0));
        do_op("rx2_bal", 3'd1, 32'd0, 16'h0, 1'b0, 0, 99000);
        eject_op("rx2_end");

        // Randomized sessions against the model
        do_reset();
        for (int s = 0; s < 40; s++) begin
            idx = $urandom_range(0, 3);
            insert("rnd_card", idx);
            if (m_lock[idx]) continue;
            home = 1'b0; gone = 1'b0;
            while (!home && !gone) begin
                if ($urandom_range(0, 2) == 0) p = 14'(8030 + idx + $urandom_range(1, 50));
                else                            p = 14'(8030 + idx);
                enter_pin("rnd_pin", p, home, gone);
            end
            if (gone) continue;
            nops = $urandom_range(1, 8);
            gone = 1'b0;
            for (int k = 0; k < nops && !gone; k++) rand_op(gone);
            if (!gone) eject_op("rnd_end");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
